// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite register slave: response codes, FSM states
// and the read/write arbitration grant.
package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      RD_REQ  = 3'd2,
      WR_RESP = 3'd3,
      RD_RESP = 3'd4
   } state_e;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } grant_e;

endpackage

// File: rtl/axil_hold_buf.sv
// One-entry holding register for an AXI-Lite channel: accepts a beat while
// empty and keeps it until the owning transaction's response completes.
module axil_hold_buf #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid,
   output logic         ready,
   input  logic [W-1:0] load_data,
   input  logic         clr,
   output logic         full,
   output logic [W-1:0] data
);

   assign ready = !full;

   // clr only arrives while full and capture only while empty, so they never collide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (clr) begin
         full <= 1'b0;
      end else if (valid && !full) begin
         full <= 1'b1;
         data <= load_data;
      end
   end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder: buffers AW/W/AR, arbitrates read vs write round-robin,
// decodes the window and runs one req/ack register access with a timeout.
module axil_reg_slave
   import axil_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                REG_AW    = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
   parameter int                TIMEOUT   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                axi_awvalid,
   output logic                axi_awready,
   input  logic [ADDR_W-1:0]   axi_awaddr,
   input  logic                axi_wvalid,
   output logic                axi_wready,
   input  logic [DATA_W-1:0]   axi_wdata,
   input  logic [DATA_W/8-1:0] axi_wstrb,
   output logic                axi_bvalid,
   input  logic                axi_bready,
   output logic [1:0]          axi_bresp,
   input  logic                axi_arvalid,
   output logic                axi_arready,
   input  logic [ADDR_W-1:0]   axi_araddr,
   output logic                axi_rvalid,
   input  logic                axi_rready,
   output logic [DATA_W-1:0]   axi_rdata,
   output logic [1:0]          axi_rresp,
   output logic                reg_req,
   output logic                reg_we,
   output logic [REG_AW-1:0]   reg_addr,
   output logic [DATA_W-1:0]   reg_wdata,
   output logic [DATA_W/8-1:0] reg_wstrb,
   input  logic                reg_ack,
   input  logic [DATA_W-1:0]   reg_rdata,
   input  logic                reg_err,
   output state_e              dbg_state
);

   localparam int                STRB_W  = DATA_W / 8;
   localparam int                CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

   // Handshakes: a beat transfers on the rising edge where valid && ready are both
   // high; a response holds valid and its payload unchanged until ready is seen.
   logic                     aw_full, w_full, ar_full;
   logic [ADDR_W-1:0]        aw_addr, ar_addr;
   logic [DATA_W+STRB_W-1:0] w_buf;
   logic [DATA_W-1:0]        w_data;
   logic [STRB_W-1:0]        w_strb;
   logic                     b_done, r_done;
   logic                     wr_elig, rd_elig, wr_hit, rd_hit;
   logic                     grant_wr, grant_rd;

   state_e            state, state_next;
   grant_e            last_grant;
   logic [CNT_W-1:0]  cnt;
   resp_e             resp;
   logic [DATA_W-1:0] rdata;

   assign b_done = axi_bvalid && axi_bready;
   assign r_done = axi_rvalid && axi_rready;

   axil_hold_buf #(.W(ADDR_W)) u_aw_buf (
      .clk(clk), .rst_n(rst_n), .valid(axi_awvalid), .ready(axi_awready),
      .load_data(axi_awaddr), .clr(b_done), .full(aw_full), .data(aw_addr)
   );

   axil_hold_buf #(.W(DATA_W + STRB_W)) u_w_buf (
      .clk(clk), .rst_n(rst_n), .valid(axi_wvalid), .ready(axi_wready),
      .load_data({axi_wdata, axi_wstrb}), .clr(b_done), .full(w_full), .data(w_buf)
   );

   axil_hold_buf #(.W(ADDR_W)) u_ar_buf (
      .clk(clk), .rst_n(rst_n), .valid(axi_arvalid), .ready(axi_arready),
      .load_data(axi_araddr), .clr(r_done), .full(ar_full), .data(ar_addr)
   );

   assign w_data  = w_buf[DATA_W+STRB_W-1:STRB_W];
   assign w_strb  = w_buf[STRB_W-1:0];
   assign wr_elig = aw_full && w_full;
   assign rd_elig = ar_full;
   assign wr_hit  = (aw_addr[ADDR_W-1:REG_AW] == BASE_ADDR[ADDR_W-1:REG_AW]);
   assign rd_hit  = (ar_addr[ADDR_W-1:REG_AW] == BASE_ADDR[ADDR_W-1:REG_AW]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      grant_wr   = 1'b0;
      grant_rd   = 1'b0;
      case (state)
         IDLE: begin
            // under contention the side that did not win last time goes first
            if (wr_elig && (!rd_elig || last_grant == READ)) begin
               grant_wr   = 1'b1;
               state_next = wr_hit ? WR_REQ : WR_RESP;
            end else if (rd_elig) begin
               grant_rd   = 1'b1;
               state_next = rd_hit ? RD_REQ : RD_RESP;
            end
         end
         WR_REQ:  if (reg_ack || cnt == CNT_MAX) state_next = WR_RESP;
         RD_REQ:  if (reg_ack || cnt == CNT_MAX) state_next = RD_RESP;
         WR_RESP: if (axi_bready) state_next = IDLE;
         RD_RESP: if (axi_rready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= READ;
         reg_we     <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_wstrb  <= '0;
         resp       <= OKAY;
         rdata      <= '0;
         cnt        <= '0;
      end else if (grant_wr) begin
         last_grant <= WRITE;
         reg_we     <= 1'b1;
         reg_addr   <= aw_addr[REG_AW-1:0];
         reg_wdata  <= w_data;
         reg_wstrb  <= w_strb;
         resp       <= wr_hit ? OKAY : DECERR;
         rdata      <= '0;
         cnt        <= '0;
      end else if (grant_rd) begin
         last_grant <= READ;
         reg_we     <= 1'b0;
         reg_addr   <= ar_addr[REG_AW-1:0];
         resp       <= rd_hit ? OKAY : DECERR;
         rdata      <= '0;
         cnt        <= '0;
      end else if (state == WR_REQ || state == RD_REQ) begin
         cnt <= cnt + CNT_W'(1);
         if (reg_ack) begin
            resp <= reg_err ? SLVERR : OKAY;
            if (state == RD_REQ) rdata <= reg_rdata;
         end else if (cnt == CNT_MAX) begin
            resp <= SLVERR;
         end
      end
   end

   assign reg_req    = (state == WR_REQ) || (state == RD_REQ);
   assign axi_bvalid = (state == WR_RESP);
   assign axi_rvalid = (state == RD_RESP);
   assign axi_bresp  = resp;
   assign axi_rresp  = resp;
   assign axi_rdata  = rdata;
   assign dbg_state  = state;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed scenarios plus randomized
// traffic scored against a transaction-level model of the expected accesses and responses.
module tb_axil_reg_slave;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
   logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
   logic [3:0]  axi_wstrb;
   logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic [1:0]  axi_bresp, axi_rresp;
   logic        reg_req, reg_we, reg_ack, reg_err;
   logic [11:0] reg_addr;
   logic [31:0] reg_wdata, reg_rdata;
   logic [3:0]  reg_wstrb;
   logic [2:0]  dbg_state;

   axil_reg_slave #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int failures = 0;
   logic [48:0] exp_acc_q[$];   // {we, addr, wdata, wstrb}, wdata/wstrb zero for reads
   logic [1:0]  exp_b_q[$];
   logic [33:0] exp_r_q[$];     // {rresp, rdata}

   int          b_cnt = 0, r_cnt = 0, b_target = 0, r_target = 0;
   int          req_rises = 0, req_len = 0, last_req_len = 0;
   int          req_rise_cyc = 0, b_rise_cyc = 0, hs_cyc = 0;
   logic [1:0]  last_bresp = 2'b0, last_rresp = 2'b0;
   logic [31:0] last_rdata = 32'h0;
   logic [11:0] last_acc_addr = 12'h0;
   logic        last_acc_we = 1'b0;

   int          plan_delay = 0;
   bit          plan_err = 1'b0;
   logic [31:0] plan_rdata = 32'h0;
   bit          late_ack = 1'b0;
   bit          bp_mode = 1'b0;
   bit          bready_force = 1'b1, rready_force = 1'b1;
   bit          model_last = 1'b0;   // 0: last grant was a read, 1: a write
   int          dly_tab[7] = '{0, 1, 2, 3, 15, 16, 40};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit in_win(input logic [31:0] addr);
      return (addr >> 12) == (32'h8000_0000 >> 12);
   endfunction

   function automatic logic [33:0] model_resp(input logic [31:0] addr, input int delay,
                                              input bit err, input logic [31:0] rd, input bit is_read);
      if (!in_win(addr))       return {2'b11, 32'h0};
      if (delay > TIMEOUT - 1) return {2'b10, 32'h0};
      return {(err ? 2'b10 : 2'b00), (is_read ? rd : 32'h0)};
   endfunction

   // ---------------- register responder ----------------
   int req_age = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         reg_ack = 1'b0;
         req_age = 0;
      end else if (late_ack) begin
         reg_ack = 1'b1;
      end else if (reg_req) begin
         reg_ack   = (req_age == plan_delay);
         reg_err   = reg_ack ? plan_err : 1'($urandom_range(0, 1));
         reg_rdata = reg_ack ? plan_rdata : $urandom;
         req_age++;
      end else begin
         reg_ack   = 1'b0;
         req_age   = 0;
         reg_err   = 1'($urandom_range(0, 1));
         reg_rdata = $urandom;
      end
   end

   // response-channel readiness, randomized when bp_mode is set
   always @(posedge clk) begin
      #1;
      axi_bready = bp_mode ? 1'($urandom_range(0, 1)) : bready_force;
      axi_rready = bp_mode ? 1'($urandom_range(0, 1)) : rready_force;
   end

   // ---------------- compare process ----------------
   logic        prev_req = 1'b0, prev_bvalid = 1'b0, prev_bready = 1'b0;
   logic        prev_rvalid = 1'b0, prev_rready = 1'b0;
   logic [48:0] prev_fields = '0;
   logic [1:0]  prev_bresp = '0;
   logic [33:0] prev_r = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0; prev_bvalid = 1'b0; prev_rvalid = 1'b0; req_len = 0;
      end else begin
         if (reg_req && !prev_req) begin
            req_rises++;
            req_rise_cyc  = cyc;
            last_acc_addr = reg_addr;
            last_acc_we   = reg_we;
            chk("req_expected", exp_acc_q.size() != 0, 1);
            if (exp_acc_q.size() != 0)
               chk("reg_access", {reg_we, reg_addr, (reg_we ? {reg_wdata, reg_wstrb} : 36'h0)},
                   exp_acc_q.pop_front());
         end
         if (reg_req && prev_req)
            chk("reg_stable", {reg_we, reg_addr, reg_wdata, reg_wstrb}, prev_fields);
         if (reg_req) begin
            req_len++;
            chk("req_len_bound", req_len <= TIMEOUT, 1);
         end else if (prev_req) begin
            last_req_len = req_len;
            req_len = 0;
         end
         if (prev_bvalid && !prev_bready) chk("b_hold", {axi_bvalid, axi_bresp}, {1'b1, prev_bresp});
         if (prev_rvalid && !prev_rready) chk("r_hold", {axi_rvalid, axi_rresp, axi_rdata}, {1'b1, prev_r});
         if (axi_bvalid && !prev_bvalid) b_rise_cyc = cyc;
         if (axi_bvalid && axi_bready) begin
            b_cnt++;
            last_bresp = axi_bresp;
            chk("b_expected", exp_b_q.size() != 0, 1);
            if (exp_b_q.size() != 0) chk("bresp", axi_bresp, exp_b_q.pop_front());
         end
         if (axi_rvalid && axi_rready) begin
            r_cnt++;
            last_rresp = axi_rresp;
            last_rdata = axi_rdata;
            chk("r_expected", exp_r_q.size() != 0, 1);
            if (exp_r_q.size() != 0) chk("rresp_rdata", {axi_rresp, axi_rdata}, exp_r_q.pop_front());
         end
         prev_req    = reg_req;
         prev_fields = {reg_we, reg_addr, reg_wdata, reg_wstrb};
         prev_bvalid = axi_bvalid;
         prev_bready = axi_bready;
         prev_bresp  = axi_bresp;
         prev_rvalid = axi_rvalid;
         prev_rready = axi_rready;
         prev_r      = {axi_rresp, axi_rdata};
      end
   end

   // ---------------- driver tasks (enter and leave at posedge+1) ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead);
      logic [33:0] m;
      int  aw_start, w_start, t;
      bit  aw_pend, w_pend, aw_fire, w_fire;
      m = model_resp(addr, plan_delay, plan_err, plan_rdata, 1'b0);
      if (in_win(addr)) exp_acc_q.push_back({1'b1, addr[11:0], data, strb});
      exp_b_q.push_back(m[33:32]);
      b_target++;
      model_last = 1'b1;
      aw_start = (w_lead > 0) ? w_lead : 0;
      w_start  = (w_lead < 0) ? -w_lead : 0;
      aw_pend = 1'b1; w_pend = 1'b1; t = 0;
      while ((aw_pend || w_pend) && t < 20) begin
         axi_awvalid = aw_pend && (t >= aw_start);
         axi_awaddr  = addr;
         axi_wvalid  = w_pend && (t >= w_start);
         axi_wdata   = data;
         axi_wstrb   = strb;
         @(negedge clk);
         aw_fire = axi_awvalid && axi_awready;
         w_fire  = axi_wvalid && axi_wready;
         if (aw_fire || w_fire) hs_cyc = cyc;
         @(posedge clk); #1;
         if (aw_fire) aw_pend = 1'b0;
         if (w_fire)  w_pend = 1'b0;
         t++;
      end
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      chk("aw_w_accepted", {aw_pend, w_pend}, 2'b00);
   endtask

   task automatic axi_read(input logic [31:0] addr);
      logic [33:0] m;
      int t;
      bit fired;
      m = model_resp(addr, plan_delay, plan_err, plan_rdata, 1'b1);
      if (in_win(addr)) exp_acc_q.push_back({1'b0, addr[11:0], 36'h0});
      exp_r_q.push_back(m);
      r_target++;
      model_last = 1'b0;
      fired = 1'b0; t = 0;
      while (!fired && t < 20) begin
         axi_arvalid = 1'b1;
         axi_araddr  = addr;
         @(negedge clk);
         fired = axi_arready;
         if (fired) hs_cyc = cyc;
         @(posedge clk); #1;
         t++;
      end
      axi_arvalid = 1'b0;
      chk("ar_accepted", fired, 1);
   endtask

   // AW, W and AR presented in the same cycle so both sides become eligible together
   task automatic axi_both(input logic [31:0] waddr, input logic [31:0] wdata, input logic [31:0] raddr);
      logic [33:0] mw, mr;
      logic [48:0] aw_e, ar_e;
      mw   = model_resp(waddr, plan_delay, plan_err, plan_rdata, 1'b0);
      mr   = model_resp(raddr, plan_delay, plan_err, plan_rdata, 1'b1);
      aw_e = {1'b1, waddr[11:0], wdata, 4'hF};
      ar_e = {1'b0, raddr[11:0], 36'h0};
      if (!model_last) begin
         if (in_win(waddr)) exp_acc_q.push_back(aw_e);
         if (in_win(raddr)) exp_acc_q.push_back(ar_e);
         model_last = 1'b0;
      end else begin
         if (in_win(raddr)) exp_acc_q.push_back(ar_e);
         if (in_win(waddr)) exp_acc_q.push_back(aw_e);
         model_last = 1'b1;
      end
      exp_b_q.push_back(mw[33:32]);
      exp_r_q.push_back(mr);
      b_target++;
      r_target++;
      axi_awvalid = 1'b1; axi_awaddr = waddr;
      axi_wvalid  = 1'b1; axi_wdata  = wdata; axi_wstrb = 4'hF;
      axi_arvalid = 1'b1; axi_araddr = raddr;
      @(negedge clk);
      chk("both_ready", {axi_awready, axi_wready, axi_arready}, 3'b111);
      @(posedge clk); #1;
      axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((b_cnt < b_target || r_cnt < r_target) && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("resp_arrived", (b_cnt >= b_target) && (r_cnt >= r_target), 1);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) < 8) return {20'h80000, 12'($urandom)};
      return $urandom;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int n0, t, op;
      rst_n = 1'b0;
      axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
      axi_awaddr = '0; axi_wdata = '0; axi_wstrb = '0; axi_araddr = '0;
      axi_bready = 1'b1; axi_rready = 1'b1;
      reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_reg_req", reg_req, 0);
      chk("rst_bvalid", axi_bvalid, 0);
      chk("rst_rvalid", axi_rvalid, 0);
      chk("rst_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);
      chk("rst_resp_rdata", {axi_bresp, axi_rresp, axi_rdata}, 36'h0);
      chk("rst_reg_out", {reg_we, reg_addr, reg_wdata, reg_wstrb}, 49'h0);
      chk("rst_state", dbg_state, 3'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single write, AW+W together, immediate ack
      plan_delay = 0; plan_err = 1'b0;
      axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
      wait_idle();
      chk("t1_req_latency", req_rise_cyc - hs_cyc, 2);
      chk("t1_b_latency", b_rise_cyc - hs_cyc, 3);
      chk("t1_reg_addr", last_acc_addr, 12'h010);
      chk("t1_reg_we", last_acc_we, 1);
      chk("t1_bresp", last_bresp, 2'b00);

      // W ahead of AW, then a read of the same register acked after 3 cycles
      n0 = req_rises;
      axi_write(32'h8000_0010, 32'hCAFE_0001, 4'h3, 2);
      wait_idle();
      plan_delay = 3; plan_rdata = 32'h1234_5678;
      axi_read(32'h8000_0010);
      wait_idle();
      chk("t2_rdata", last_rdata, 32'h1234_5678);
      chk("t2_rresp", last_rresp, 2'b00);
      chk("t2_req_count", req_rises - n0, 2);

      // out-of-window read
      n0 = req_rises;
      axi_read(32'h4000_0000);
      wait_idle();
      chk("t3_no_req", req_rises - n0, 0);
      chk("t3_rresp", last_rresp, 2'b11);
      chk("t3_rdata", last_rdata, 32'h0);

      // unresponsive register, then a stray ack while the response waits
      plan_delay = 40; rready_force = 1'b0;
      axi_read(32'h8000_0020);
      t = 0;
      while (!axi_rvalid && t < 60) begin @(negedge clk); t++; end
      @(negedge clk);
      chk("t4_req_len", last_req_len, TIMEOUT);
      @(posedge clk); #1;
      late_ack = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      late_ack = 1'b0;
      @(negedge clk);
      chk("t4_hold", {axi_rvalid, axi_rresp, axi_rdata}, {1'b1, 2'b10, 32'h0});
      rready_force = 1'b1;
      wait_idle();
      chk("t4_rresp", last_rresp, 2'b10);
      chk("t4_rdata", last_rdata, 32'h0);

      // reset in the middle of a register access
      axi_read(32'h8000_0044);
      t = 0;
      while (!reg_req && t < 10) begin @(negedge clk); t++; end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t5_req_drop", reg_req, 0);
      chk("t5_valids", {axi_bvalid, axi_rvalid}, 2'b00);
      exp_acc_q.delete(); exp_b_q.delete(); exp_r_q.delete();
      b_target = b_cnt; r_target = r_cnt;
      model_last = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t5_readies", {axi_awready, axi_wready, axi_arready}, 3'b111);

      // contention straight after reset, a lone write, then contention again
      plan_delay = 0; plan_err = 1'b0; plan_rdata = 32'hA5A5_0001;
      axi_both(32'h8000_0100, 32'h0000_1111, 32'h8000_0104);
      wait_idle();
      axi_write(32'h8000_0108, 32'h0000_2222, 4'hF, -1);
      wait_idle();
      chk("t5_write_ok", last_bresp, 2'b00);
      axi_both(32'h8000_010C, 32'h0000_3333, 32'h8000_0110);
      wait_idle();

      // write response held off for 5 cycles
      bready_force = 1'b0; plan_delay = 2;
      axi_write(32'h8000_0200, 32'h5555_AAAA, 4'hF, 0);
      t = 0;
      while (!axi_bvalid && t < 50) begin @(negedge clk); t++; end
      repeat (5) @(negedge clk);
      chk("t6_stall", {axi_bvalid, axi_bresp}, 3'b100);
      bready_force = 1'b1;
      wait_idle();

      // randomized traffic with response back-pressure
      bp_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         plan_delay = dly_tab[$urandom_range(0, 6)];
         plan_err   = 1'($urandom_range(0, 1));
         plan_rdata = $urandom;
         case (op)
            0:       axi_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 4) - 2);
            1:       axi_read(rand_addr());
            default: axi_both(rand_addr(), $urandom, rand_addr());
         endcase
         wait_idle();
      end
      bp_mode = 1'b0;
      repeat (3) @(posedge clk);

      chk("acc_q_empty", exp_acc_q.size(), 0);
      chk("b_q_empty", exp_b_q.size(), 0);
      chk("r_q_empty", exp_r_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
